// File: rtl/btn_event_arbiter.sv
// Push-button front end: per-button debounce, SHORT/LONG press
// classification and a round-robin funnel onto one event port.
module btn_event_arbiter #(
  parameter int N_BTN   = 4,
  parameter int DB_MS   = 5,
  parameter int LONG_MS = 1000
) (
  input  logic                     clk_1kHz,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_long,
  output logic                     evt_overrun
);

  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(DB_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } press_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  press_e           state_q [N_BTN];
  press_e           state_d [N_BTN];
  logic [HW-1:0]    hc_q [N_BTN];
  logic [HW-1:0]    hc_d [N_BTN];
  logic [N_BTN-1:0] post;
  logic [N_BTN-1:0] post_long;

  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] pend_d;
  logic [N_BTN-1:0] pend_long_q;
  logic [N_BTN-1:0] pend_long_d;
  logic             overrun_q;
  logic             overrun_d;

  logic [N_BTN-1:0] avail;
  logic             found;
  logic [IW-1:0]    sel;
  logic             load;
  logic             valid_q;
  logic             valid_d;
  logic [IW-1:0]    id_q;
  logic [IW-1:0]    id_d;
  logic             long_q;
  logic             long_d;
  logic [IW-1:0]    lg_q;
  logic [IW-1:0]    lg_d;

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      pend_q      <= '0;
      pend_long_q <= '0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      id_q        <= '0;
      long_q      <= 1'b0;
      lg_q        <= IW'(N_BTN - 1);
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]   <= '0;
        hc_q[i]    <= '0;
        state_q[i] <= S_IDLE;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      long_q      <= long_d;
      lg_q        <= lg_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hc_q[i]    <= hc_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  // Level only moves after DB_MS consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CW'(DB_MS - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    post      = '0;
    post_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      hc_d[i]    = hc_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (level_q[i]) begin
            state_d[i] = S_PRESSED;
            hc_d[i]    = '0;
          end
        end
        S_PRESSED: begin
          if (!level_q[i]) begin
            post[i]    = 1'b1;
            state_d[i] = S_IDLE;
          end else if (hc_q[i] == HW'(LONG_MS - 1)) begin
            post[i]      = 1'b1;
            post_long[i] = 1'b1;
            state_d[i]   = S_HELD;
          end else begin
            hc_d[i] = hc_q[i] + HW'(1);
          end
        end
        S_HELD: begin
          if (!level_q[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // A fresh post may bypass its empty slot straight into the output.
  assign avail = pend_q | post;

  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = int'(lg_q) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign load = (!valid_q || evt_ready) && found;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    long_d  = long_q;
    lg_d    = lg_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = sel;
      long_d  = pend_q[sel] ? pend_long_q[sel] : post_long[sel];
      lg_d    = sel;
    end else if (evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    overrun_d   = overrun_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (load && sel == IW'(i)) begin
        pend_d[i] = 1'b0;
        if (post[i] && pend_q[i]) begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = post_long[i];
        end
      end else if (post[i]) begin
        pend_d[i]      = 1'b1;
        pend_long_d[i] = post_long[i];
        if (pend_q[i]) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  assign btn_level   = level_q;
  assign evt_valid   = valid_q;
  assign evt_id      = id_q;
  assign evt_long    = long_q;
  assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with DB_MS=5, LONG_MS=20.
module tb_btn_event_arbiter;

  localparam int N  = 4;
  localparam int DB = 5;
  localparam int LM = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic         evt_long;
  logic         evt_overrun;

  int vecs = 0;
  int errs = 0;
  logic [1:0] q_id[$];
  logic       q_long[$];

  always #5 clk = ~clk;

  btn_event_arbiter #(
    .N_BTN   (N),
    .DB_MS   (DB),
    .LONG_MS (LM)
  ) dut (
    .clk_1kHz    (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_long    (evt_long),
    .evt_overrun (evt_overrun)
  );

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      q_id.push_back(evt_id);
      q_long.push_back(evt_long);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    q_id.delete();
    q_long.delete();
  endtask

  initial begin
    rst       = 1'b1;
    btn_raw   = '0;
    evt_ready = 1'b1;
    tick(2);
    check_eq("rst_level", 32'(btn_level), 0);
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_id", 32'(evt_id), 0);
    check_eq("rst_long", 32'(evt_long), 0);
    check_eq("rst_ovr", 32'(evt_overrun), 0);
    rst = 1'b0;

    // 1: bounce burst then a clean edge
    do_reset();
    btn_raw[0] = 1'b1; tick(1);
    btn_raw[0] = 1'b0; tick(1);
    btn_raw[0] = 1'b1; tick(1);
    btn_raw[0] = 1'b0; tick(1);
    tick(10);
    check_eq("t1_burst_lvl", 32'(btn_level[0]), 0);
    check_eq("t1_burst_evt", 32'(q_id.size()), 0);
    btn_raw[0] = 1'b1;
    tick(6);
    check_eq("t1_edge6", 32'(btn_level[0]), 0);
    tick(1);
    check_eq("t1_edge7", 32'(btn_level[0]), 1);
    btn_raw[0] = 1'b0;
    tick(12);

    // 2: short press on btn 0
    do_reset();
    btn_raw[0] = 1'b1;
    tick(7);
    check_eq("t2_rise", 32'(btn_level[0]), 1);
    tick(3);
    btn_raw[0] = 1'b0;
    tick(7);
    check_eq("t2_fall", 32'(btn_level[0]), 0);
    check_eq("t2_pre_valid", 32'(evt_valid), 0);
    tick(1);
    check_eq("t2_valid", 32'(evt_valid), 1);
    check_eq("t2_id", 32'(evt_id), 0);
    check_eq("t2_long", 32'(evt_long), 0);
    tick(1);
    check_eq("t2_drop", 32'(evt_valid), 0);
    tick(30);
    check_eq("t2_count", 32'(q_id.size()), 1);

    // 3: long press on btn 2
    do_reset();
    btn_raw[2] = 1'b1;
    tick(7);
    check_eq("t3_rise", 32'(btn_level[2]), 1);
    tick(20);
    check_eq("t3_pre_valid", 32'(evt_valid), 0);
    tick(1);
    check_eq("t3_valid", 32'(evt_valid), 1);
    check_eq("t3_id", 32'(evt_id), 2);
    check_eq("t3_long", 32'(evt_long), 1);
    tick(9);
    btn_raw[2] = 1'b0;
    tick(20);
    check_eq("t3_count", 32'(q_id.size()), 1);

    // 4: simultaneous releases, round-robin order
    do_reset();
    btn_raw = 4'b1010;
    tick(10);
    btn_raw = 4'b0000;
    tick(7);
    check_eq("t4a_pre", 32'(evt_valid), 0);
    tick(1);
    check_eq("t4a_v0", 32'(evt_valid), 1);
    check_eq("t4a_id0", 32'(evt_id), 1);
    tick(1);
    check_eq("t4a_v1", 32'(evt_valid), 1);
    check_eq("t4a_id1", 32'(evt_id), 3);
    tick(1);
    check_eq("t4a_end", 32'(evt_valid), 0);
    btn_raw = 4'b0011;
    tick(10);
    btn_raw = 4'b0000;
    tick(8);
    check_eq("t4b_id0", 32'(evt_id), 0);
    check_eq("t4b_v0", 32'(evt_valid), 1);
    tick(1);
    check_eq("t4b_id1", 32'(evt_id), 1);
    check_eq("t4b_v1", 32'(evt_valid), 1);
    tick(1);
    check_eq("t4b_end", 32'(evt_valid), 0);

    // 5: backpressure and slot overwrite on btn 2
    do_reset();
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1; tick(10);
    btn_raw[2] = 1'b0; tick(8);
    check_eq("t5_first_v", 32'(evt_valid), 1);
    check_eq("t5_first_id", 32'(evt_id), 2);
    btn_raw[2] = 1'b1; tick(10);
    btn_raw[2] = 1'b0; tick(8);
    check_eq("t5_no_ovr", 32'(evt_overrun), 0);
    btn_raw[2] = 1'b1; tick(32);
    btn_raw[2] = 1'b0; tick(10);
    check_eq("t5_ovr", 32'(evt_overrun), 1);
    check_eq("t5_hold_v", 32'(evt_valid), 1);
    check_eq("t5_hold_id", 32'(evt_id), 2);
    check_eq("t5_hold_long", 32'(evt_long), 0);
    evt_ready = 1'b1;
    tick(3);
    check_eq("t5_hs_count", 32'(q_id.size()), 2);
    if (q_id.size() == 2) begin
      check_eq("t5_hs0_long", 32'(q_long[0]), 0);
      check_eq("t5_hs1_id", 32'(q_id[1]), 2);
      check_eq("t5_hs1_long", 32'(q_long[1]), 1);
    end
    check_eq("t5_end", 32'(evt_valid), 0);
    check_eq("t5_ovr_sticky", 32'(evt_overrun), 1);

    // 6: reset in the middle of a hold
    do_reset();
    check_eq("t6_ovr_clr", 32'(evt_overrun), 0);
    evt_ready = 1'b0;
    btn_raw[3] = 1'b1; tick(10);
    btn_raw[3] = 1'b0; tick(8);
    check_eq("t6_pre_id", 32'(evt_id), 3);
    btn_raw[1] = 1'b1;
    tick(7);
    tick(11);
    rst = 1'b1;
    tick(1);
    check_eq("t6_level", 32'(btn_level), 0);
    check_eq("t6_valid", 32'(evt_valid), 0);
    check_eq("t6_id", 32'(evt_id), 0);
    check_eq("t6_long", 32'(evt_long), 0);
    check_eq("t6_ovr", 32'(evt_overrun), 0);
    rst = 1'b0;
    evt_ready = 1'b1;
    q_id.delete();
    q_long.delete();
    tick(3);
    btn_raw[1] = 1'b0;
    tick(30);
    check_eq("t6_lvl_after", 32'(btn_level[1]), 0);
    check_eq("t6_no_evt", 32'(q_id.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
